// File: rtl/tb_cmd_arbiter_if.sv
// Requester/decoder bundle shared between the command arbiter and its users.
// Commands are packed per requester; requester k occupies bits [k*CMD_WIDTH +: CMD_WIDTH].
interface tb_cmd_arbiter_if #(
  parameter int REQ_NB    = 4,
  parameter int CMD_WIDTH = 64
) ();
  localparam int ID_W = $clog2(REQ_NB);

  logic [REQ_NB-1:0]                req_valid;
  logic [REQ_NB-1:0][CMD_WIDTH-1:0] req_cmd;
  logic [REQ_NB-1:0]                req_ack;
  logic [CMD_WIDTH-1:0]             args;
  logic                             args_valid;
  logic                             ack;
  logic [ID_W-1:0]                  grant_id;
  logic                             busy;
  logic                             timeout;
  logic [7:0]                       timeout_cnt;

  modport master (
    output req_valid, req_cmd, ack,
    input  req_ack, args, args_valid, grant_id, busy, timeout, timeout_cnt
  );

  modport slave (
    input  req_valid, req_cmd, ack,
    output req_ack, args, args_valid, grant_id, busy, timeout, timeout_cnt
  );
endinterface

// File: rtl/tb_cmd_arbiter.sv
// Round-robin arbiter feeding one command decoder from REQ_NB sequencers.
// Define TB_CMD_ARBITER_WATCHDOG_EN to compile in the grant watchdog.
module tb_cmd_arbiter #(
  parameter int REQ_NB         = 4,
  parameter int CMD_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  tb_cmd_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(REQ_NB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} state_t;

  typedef struct packed {
    logic            hit;
    logic [ID_W-1:0] id;
  } pick_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  pick_t           pick;
  logic            wd_fire;
  logic            unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin : pick_c
    int j;
    j    = 0;
    pick = '0;
    for (int i = REQ_NB-1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= REQ_NB) j = j - REQ_NB;
      if (bus.req_valid[ID_W'(j)]) begin
        pick.hit = 1'b1;
        pick.id  = ID_W'(j);
      end
    end
  end

`ifdef TB_CMD_ARBITER_WATCHDOG_EN
  logic [15:0] wd_cnt;
  // A same-cycle decoder ack wins over expiry.
  assign wd_fire = (wd_cnt == 16'(TIMEOUT_CYCLES-1)) && !bus.ack;
`else
  assign wd_fire          = 1'b0;
  assign bus.timeout      = 1'b0;
  assign bus.timeout_cnt  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.req_ack    <= '0;
      bus.args       <= '0;
      bus.args_valid <= 1'b0;
      bus.grant_id   <= '0;
      bus.busy       <= 1'b0;
`ifdef TB_CMD_ARBITER_WATCHDOG_EN
      wd_cnt          <= '0;
      bus.timeout     <= 1'b0;
      bus.timeout_cnt <= '0;
`endif
    end else begin
      bus.req_ack    <= '0;
      bus.args_valid <= 1'b0;
`ifdef TB_CMD_ARBITER_WATCHDOG_EN
      bus.timeout    <= 1'b0;
`endif
      case (state)
        IDLE: if (pick.hit) begin
          state          <= ISSUE;
          bus.busy       <= 1'b1;
          bus.args_valid <= 1'b1;
          bus.args       <= bus.req_cmd[pick.id];
          bus.grant_id   <= pick.id;
          ptr            <= (pick.id == ID_W'(REQ_NB-1)) ? '0 : pick.id + 1'b1;
`ifdef TB_CMD_ARBITER_WATCHDOG_EN
          wd_cnt         <= '0;
`endif
        end
        ISSUE, WAIT_ACK: begin
          if (bus.ack || wd_fire) begin
            state                     <= RELEASE;
            bus.req_ack[bus.grant_id] <= 1'b1;
          end else begin
            state <= WAIT_ACK;
          end
`ifdef TB_CMD_ARBITER_WATCHDOG_EN
          if (wd_fire) begin
            bus.timeout <= 1'b1;
            if (bus.timeout_cnt != 8'hFF) bus.timeout_cnt <= bus.timeout_cnt + 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Requester valids are ignored here so the stale valid is not re-granted.
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
